fht_ibfly: RTL and testbench

Inverse Fast Hartley Transform butterfly. Takes the additive/subtractive pair produced by a forward butterfly (c = a+b, d = a−b, each N+1 bits signed) and recovers the original N-bit operands a = (c+d)/2, b = (c−d)/2. It sits on the inverse 2-D FHT datapath and is pipelined with valid/ready flow control on both sides. Optional checks flag pairs that no forward butterfly could have produced.

---
 rtl/fht_pkg.sv | 14 +
 rtl/fht_ibfly_stage.sv | 34 +++
 rtl/fht_ibfly.sv | 114 +++++++++++
 tb/tb_fht_ibfly.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_pkg.sv
// Shared FHT butterfly definitions: default widths and error-code bit positions,
// used by both the forward and inverse butterflies.
package fht_pkg;

    localparam int N_DEF   = 8;
    localparam int ECW_DEF = 8;

    localparam int ERR_PARITY_BIT = 0;
    localparam int ERR_RANGE_BIT  = 1;
    localparam int ERR_W          = 2;

    typedef logic [ERR_W-1:0] err_vec_t;

endpackage

// File: rtl/fht_ibfly_stage.sv
// Single valid/ready register slice: on i_adv it takes i_valid and, when that is
// set, captures i_data; otherwise valid and data hold.
module fht_ibfly_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_adv,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // NOTE: non-blocking assignments so chained slices all sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fht_ibfly.sv
// Inverse FHT butterfly: recovers a=(c+d)/2, b=(c-d)/2 through two register slices.
// Define FHT_IBFLY_CHK_EN to build the parity/range checks, sticky flags and err_cnt.
module fht_ibfly
    import fht_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int ECW = ECW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N:0]     c,
    input  logic [N:0]     d,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   a,
    output logic [N-1:0]   b,
    input  logic           clr_err,
    output logic           err_parity,
    output logic           err_range,
    output logic [ECW-1:0] err_cnt
);

    logic           w_v1;
    logic [2*N+1:0] w_s1_data;
    logic [N:0]     w_c1;
    logic [N:0]     w_d1;
    logic [N+1:0]   w_sum;
    logic [N+1:0]   w_dif;
    logic [2*N-1:0] w_s2_data;
    logic           w_adv2;
    logic           w_move;

    assign w_adv2   = !out_valid || out_ready;
    assign in_ready = !w_v1 || w_adv2;
    assign w_move   = w_v1 && w_adv2;

    fht_ibfly_stage #(.W(2*N+2)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (in_ready),
        .i_valid (in_valid),
        .i_data  ({c, d}),
        .o_valid (w_v1),
        .o_data  (w_s1_data)
    );

    assign w_c1 = w_s1_data[2*N+1:N+1];
    assign w_d1 = w_s1_data[N:0];

    // One guard bit makes sum/difference exact even for two minimum-negative inputs.
    assign w_sum = {w_c1[N], w_c1} + {w_d1[N], w_d1};
    assign w_dif = {w_c1[N], w_c1} - {w_d1[N], w_d1};

    fht_ibfly_stage #(.W(2*N)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_adv2),
        .i_valid (w_v1),
        .i_data  ({w_sum[N:1], w_dif[N:1]}),
        .o_valid (out_valid),
        .o_data  (w_s2_data)
    );

    assign a = w_s2_data[2*N-1:N];
    assign b = w_s2_data[N-1:0];

`ifdef FHT_IBFLY_CHK_EN
    localparam logic [ECW-1:0] CNT_ONE = ECW'(1);

    err_vec_t       w_fault;
    logic           r_err_parity;
    logic           r_err_range;
    logic [ECW-1:0] r_err_cnt;
    logic           w_unused;

    // Faults are only meaningful on the cycle the pair actually moves into S2.
    assign w_fault[ERR_PARITY_BIT] = w_move && (w_c1[0] != w_d1[0]);
    assign w_fault[ERR_RANGE_BIT]  = w_move && ((w_sum[N+1] != w_sum[N]) ||
                                                (w_dif[N+1] != w_dif[N]));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_parity <= 1'b0;
            r_err_range  <= 1'b0;
            r_err_cnt    <= '0;
        end else if (clr_err) begin
            r_err_parity <= w_fault[ERR_PARITY_BIT];
            r_err_range  <= w_fault[ERR_RANGE_BIT];
            r_err_cnt    <= (|w_fault) ? CNT_ONE : '0;
        end else begin
            r_err_parity <= r_err_parity | w_fault[ERR_PARITY_BIT];
            r_err_range  <= r_err_range  | w_fault[ERR_RANGE_BIT];
            if ((|w_fault) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end
        end
    end

    assign err_parity = r_err_parity;
    assign err_range  = r_err_range;
    assign err_cnt    = r_err_cnt;
    assign w_unused   = ^{w_sum[0], w_dif[0]};
`else
    logic w_unused;

    assign err_parity = 1'b0;
    assign err_range  = 1'b0;
    assign err_cnt    = '0;
    assign w_unused   = ^{w_sum[0], w_dif[0], w_sum[N+1], w_dif[N+1], clr_err, w_move};
`endif

endmodule

// File: tb/tb_fht_ibfly.sv
// Directed self-checking bench for fht_ibfly (N=8, ECW=8); error expectations
// follow whether FHT_IBFLY_CHK_EN is defined for the build.
module tb_fht_ibfly;

`ifdef FHT_IBFLY_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] c;
    logic [8:0] d;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr_err;
    logic       err_parity;
    logic       err_range;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    fht_ibfly #(.N(8), .ECW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .c          (c),
        .d          (d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a          (a),
        .b          (b),
        .clr_err    (clr_err),
        .err_parity (err_parity),
        .err_range  (err_range),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offers one pair with out_ready high and checks the two-stage latency and result.
    task automatic one_pair(input string tag, input logic [8:0] ci, input logic [8:0] di,
                            input logic [7:0] ea, input logic [7:0] eb,
                            input logic ep, input logic er, input logic [7:0] ecnt);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        c         = ci;
        d         = di;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        cyc();
        in_valid = 1'b0;
        c        = '0;
        d        = '0;
        @(negedge clk);
        check({tag, "_early_valid"}, out_valid, 0);
        cyc();
        @(negedge clk);
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_a"}, a, ea);
        check({tag, "_b"}, b, eb);
        check({tag, "_err_parity"}, err_parity, ep);
        check({tag, "_err_range"}, err_range, er);
        check({tag, "_err_cnt"}, err_cnt, ecnt);
        cyc();
    endtask

    initial begin
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [7:0] ra, rb, pa, pb, ea, eb;
        int         sent, got, occ;
        bit         prev_stall;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        c         = '0;
        d         = '0;
        clr_err   = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_err_parity", err_parity, 0);
        check("rst_err_range", err_range, 0);
        check("rst_err_cnt", err_cnt, 0);
        cyc();

        one_pair("basic", 9'h07F, 9'h049, 8'h64, 8'h1B, 1'b0, 1'b0, 8'h00);
        one_pair("minneg", 9'h100, 9'h000, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00);
        one_pair("mixed", 9'h1FF, 9'h0FF, 8'h7F, 8'h80, 1'b0, 1'b0, 8'h00);
        one_pair("parity", 9'h003, 9'h002, 8'h02, 8'h00, CHK, 1'b0, CHK ? 8'h01 : 8'h00);

        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        @(negedge clk);
        check("clr_err_parity", err_parity, 0);
        check("clr_err_cnt", err_cnt, 0);
        cyc();

        one_pair("range", 9'h0FF, 9'h0FF, 8'hFF, 8'h00, 1'b0, CHK, CHK ? 8'h01 : 8'h00);

        // 300 more range faults at full rate drive the counter into saturation.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        c         = 9'h0FF;
        d         = 9'h0FF;
        repeat (300) cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("sat_err_cnt", err_cnt, CHK ? 8'hFF : 8'h00);
        check("sat_err_range", err_range, CHK);
        check("sat_out_valid", out_valid, 0);
        cyc();

        // Fault moving into S2 on the same edge as clr_err: the fault wins.
        in_valid = 1'b1;
        c        = 9'h003;
        d        = 9'h002;
        cyc();
        in_valid = 1'b0;
        clr_err  = 1'b1;
        cyc();
        clr_err = 1'b0;
        @(negedge clk);
        check("clrwin_out_valid", out_valid, 1);
        check("clrwin_a", a, 8'h02);
        check("clrwin_err_parity", err_parity, CHK);
        check("clrwin_err_range", err_range, 0);
        check("clrwin_err_cnt", err_cnt, CHK ? 8'h01 : 8'h00);
        cyc();

        // Stream 16 legal pairs with out_ready toggling 1,0,1,0...
        sent       = 0;
        got        = 0;
        prev_stall = 1'b0;
        pa         = '0;
        pb         = '0;
        ra         = 8'($urandom_range(0, 255));
        rb         = 8'($urandom_range(0, 255));
        for (int t = 0; t < 200 && got < 16; t++) begin
            out_ready = (t % 2 == 0);
            in_valid  = (sent < 16);
            c         = {ra[7], ra} + {rb[7], rb};
            d         = {ra[7], ra} - {rb[7], rb};
            @(negedge clk);
            occ = qa.size();
            if (prev_stall) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_a", a, pa);
                check("stall_hold_b", b, pb);
            end
            check("stream_in_ready", in_ready, !(occ == 2 && !out_ready));
            if (out_valid && out_ready) begin
                if (qa.size() == 0) begin
                    check("stream_spurious_out", out_valid, 0);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    check("stream_a", a, ea);
                    check("stream_b", b, eb);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                qa.push_back(ra);
                qb.push_back(rb);
                sent++;
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
            end
            prev_stall = out_valid && !out_ready;
            pa         = a;
            pb         = b;
            cyc();
        end
        in_valid = 1'b0;
        check("stream_count", got, 16);
        check("stream_err_cnt", err_cnt, CHK ? 8'h01 : 8'h00);

        // Fill both stages with faulty pairs, then reset mid-stream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        c         = 9'h003;
        d         = 9'h002;
        cyc();
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("pre_rst_err_parity", err_parity, CHK);
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_a", a, 0);
        check("midrst_b", b, 0);
        check("midrst_err_parity", err_parity, 0);
        check("midrst_err_range", err_range, 0);
        check("midrst_err_cnt", err_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            check("midrst_drained", out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
